// File: rtl/sdram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbiter_pkg
// Description : Shared memory definitions for the SDRAM arbiter: transaction
//               FSM state encoding, access size codes and port indices.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_arbiter_pkg;

    // Arbiter transaction FSM
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Access size codes carried on *_rd_wr_size
    localparam logic [1:0] BYTE   = 2'b00;
    localparam logic [1:0] HALF   = 2'b01;
    localparam logic [1:0] WORD   = 2'b10;
    localparam logic [1:0] DOUBLE = 2'b11;

    // Bit positions inside the request / grant vectors
    localparam int PORT_INST = 0;
    localparam int PORT_DATA = 1;

endpackage : sdram_arbiter_pkg
`default_nettype wire

// File: rtl/sdram_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-requester grant selector. Single requests are granted
//               directly; on a tie either the port not granted last wins
//               (ROUND_ROBIN=1) or the data port always wins (ROUND_ROBIN=0).
// Ports       : req        - request vector, bit 0 inst, bit 1 data
//               last_grant - 1 when the previous grant went to the data port
//               grant      - one-hot grant (all zero when no request)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import sdram_arbiter_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            if ((ROUND_ROBIN != 0) && last_grant) begin
                grant[PORT_INST] = 1'b1;
            end else begin
                grant[PORT_DATA] = 1'b1;
            end
        end else begin
            grant = req;
        end
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbiter
// Description : Shares one SDRAM controller between an instruction read port
//               and a data read/write port. One transaction at a time:
//               IDLE (grant+latch) -> ISSUE (hold enable until busy) ->
//               WAIT (until busy drops, capture read data) -> DONE (ack).
// Ports       : clock, reset_n (async, active low)
//               inst_*  - instruction port: read request, address, data, ack
//               data_*  - data port: rd/wr request, address, size, data, ack
//               mem_*   - SDRAM controller request fields / busy / read data
//               arb_grant_data - owner of the current or last transaction
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int ROUND_ROBIN = 1,
    parameter int ADDR_W      = 26
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              inst_rd_enable,
    input  logic [ADDR_W-1:0] inst_address,
    output logic [63:0]       inst_read_data,
    output logic              inst_ack,
    input  logic              data_rd_enable,
    input  logic              data_wr_enable,
    input  logic [ADDR_W-1:0] data_address,
    input  logic [1:0]        data_rd_wr_size,
    input  logic [63:0]       data_write_data,
    output logic [63:0]       data_read_data,
    output logic              data_ack,
    output logic              mem_rd_enable,
    output logic              mem_wr_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [1:0]        mem_rd_wr_size,
    output logic [63:0]       mem_write_data,
    input  logic              mem_busy,
    input  logic [63:0]       mem_read_data,
    output logic              arb_grant_data
);

    state_t     state;
    state_t     state_next;
    logic [1:0] grant;
    logic       wr_op;     // latched direction; mem_wr_enable drops in ISSUE

    rr_arbiter2 #(
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_rr_arbiter2 (
        .req        ({data_rd_enable | data_wr_enable, inst_rd_enable}),
        .last_grant (arb_grant_data),
        .grant      (grant)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (grant != 2'b00) state_next = ST_ISSUE;
            ST_ISSUE: if (mem_busy)       state_next = ST_WAIT;
            ST_WAIT:  if (!mem_busy)      state_next = ST_DONE;
            ST_DONE:                      state_next = ST_IDLE;
            default:                      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_rd_enable  <= 1'b0;
            mem_wr_enable  <= 1'b0;
            mem_address    <= '0;
            mem_rd_wr_size <= 2'b00;
            mem_write_data <= '0;
            wr_op          <= 1'b0;
            arb_grant_data <= 1'b0;
            inst_read_data <= '0;
            data_read_data <= '0;
            inst_ack       <= 1'b0;
            data_ack       <= 1'b0;
        end else begin
            // Acks are single-cycle: only the WAIT->DONE edge raises them
            inst_ack <= 1'b0;
            data_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant[PORT_DATA]) begin
                        arb_grant_data <= 1'b1;
                        mem_address    <= data_address;
                        mem_rd_wr_size <= data_rd_wr_size;
                        mem_write_data <= data_write_data;
                        // A master asserting both enables is performing a write
                        mem_wr_enable  <= data_wr_enable;
                        mem_rd_enable  <= ~data_wr_enable;
                        wr_op          <= data_wr_enable;
                    end else if (grant[PORT_INST]) begin
                        arb_grant_data <= 1'b0;
                        mem_address    <= inst_address;
                        mem_rd_wr_size <= WORD;
                        mem_write_data <= '0;
                        mem_wr_enable  <= 1'b0;
                        mem_rd_enable  <= 1'b1;
                        wr_op          <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (mem_busy) begin
                        mem_rd_enable <= 1'b0;
                        mem_wr_enable <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    // Capture on entry to DONE so data is valid alongside ack
                    if (!mem_busy) begin
                        if (arb_grant_data) begin
                            data_ack <= 1'b1;
                            if (!wr_op) data_read_data <= mem_read_data;
                        end else begin
                            inst_ack <= 1'b1;
                            if (!wr_op) inst_read_data <= mem_read_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : sdram_arbiter
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_arbiter
// Description : Directed self-checking bench. Instance 0 uses round-robin
//               arbitration, instance 1 fixed priority; each instance has its
//               own SDRAM controller model (busy one cycle after an enable,
//               held for five cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;

    localparam int N = 2;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [N-1:0]      inst_rd_enable;
    logic [25:0]       inst_address    [N];
    logic [63:0]       inst_read_data  [N];
    logic [N-1:0]      inst_ack;
    logic [N-1:0]      data_rd_enable;
    logic [N-1:0]      data_wr_enable;
    logic [25:0]       data_address    [N];
    logic [1:0]        data_rd_wr_size [N];
    logic [63:0]       data_write_data [N];
    logic [63:0]       data_read_data  [N];
    logic [N-1:0]      data_ack;
    logic [N-1:0]      mem_rd_enable;
    logic [N-1:0]      mem_wr_enable;
    logic [25:0]       mem_address     [N];
    logic [1:0]        mem_rd_wr_size  [N];
    logic [63:0]       mem_write_data  [N];
    logic [N-1:0]      mem_busy;
    logic [63:0]       mem_read_data   [N];
    logic [N-1:0]      arb_grant_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < N; g++) begin : g_dut
        sdram_arbiter #(
            .ROUND_ROBIN ((g == 0) ? 1 : 0),
            .ADDR_W      (26)
        ) u_dut (
            .clock           (clock),
            .reset_n         (reset_n),
            .inst_rd_enable  (inst_rd_enable[g]),
            .inst_address    (inst_address[g]),
            .inst_read_data  (inst_read_data[g]),
            .inst_ack        (inst_ack[g]),
            .data_rd_enable  (data_rd_enable[g]),
            .data_wr_enable  (data_wr_enable[g]),
            .data_address    (data_address[g]),
            .data_rd_wr_size (data_rd_wr_size[g]),
            .data_write_data (data_write_data[g]),
            .data_read_data  (data_read_data[g]),
            .data_ack        (data_ack[g]),
            .mem_rd_enable   (mem_rd_enable[g]),
            .mem_wr_enable   (mem_wr_enable[g]),
            .mem_address     (mem_address[g]),
            .mem_rd_wr_size  (mem_rd_wr_size[g]),
            .mem_write_data  (mem_write_data[g]),
            .mem_busy        (mem_busy[g]),
            .mem_read_data   (mem_read_data[g]),
            .arb_grant_data  (arb_grant_data[g])
        );

        // Controller model
        logic busy_r;
        int   cnt;
        assign mem_busy[g] = busy_r;
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                busy_r <= 1'b0;
                cnt    <= 0;
            end else if (cnt == 0) begin
                if (mem_rd_enable[g] | mem_wr_enable[g]) begin
                    busy_r <= 1'b1;
                    cnt    <= 5;
                end
            end else begin
                cnt    <= cnt - 1;
                busy_r <= (cnt > 1);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Waits for the ack of one port; lat = edges from request to ack, -1 on timeout
    task automatic wait_ack(input int k, input bit port_data, output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (port_data ? data_ack[k] : inst_ack[k]) begin
                if (port_data) begin
                    data_rd_enable[k] = 1'b0;
                    data_wr_enable[k] = 1'b0;
                end else begin
                    inst_rd_enable[k] = 1'b0;
                end
                lat = i;
                break;
            end
        end
    endtask

    // Inst read and data write raised together; first = 1 if data acked first
    task automatic tie(input int k, input logic [63:0] rdata, output int first, output int ok);
        bit di, dd;
        di = 0; dd = 0; first = -1;
        mem_read_data[k]   = rdata;
        inst_address[k]    = 26'h0000100;
        inst_rd_enable[k]  = 1'b1;
        data_address[k]    = 26'h0000200;
        data_rd_wr_size[k] = 2'b11;
        data_write_data[k] = 64'h0BAD_F00D_0BAD_F00D;
        data_wr_enable[k]  = 1'b1;
        for (int i = 0; i < 60 && !(di && dd); i++) begin
            tick();
            if (inst_ack[k] && !di) begin
                di = 1; inst_rd_enable[k] = 1'b0;
                if (first < 0) first = 0;
            end
            if (data_ack[k] && !dd) begin
                dd = 1; data_wr_enable[k] = 1'b0;
                if (first < 0) first = 1;
            end
        end
        ok = (di && dd) ? 1 : 0;
    endtask

    initial begin
        int lat, first, ok;
        bit seen;

        reset_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            inst_rd_enable[k]  = 1'b0;
            inst_address[k]    = '0;
            data_rd_enable[k]  = 1'b0;
            data_wr_enable[k]  = 1'b0;
            data_address[k]    = '0;
            data_rd_wr_size[k] = '0;
            data_write_data[k] = '0;
            mem_read_data[k]   = '0;
        end
        repeat (3) tick();

        // Reset state
        check("rst_mem_rd_enable", 64'(mem_rd_enable[0]), 64'd0);
        check("rst_mem_wr_enable", 64'(mem_wr_enable[0]), 64'd0);
        check("rst_mem_address",   64'(mem_address[0]), 64'd0);
        check("rst_arb_grant",     64'(arb_grant_data[0]), 64'd0);
        check("rst_acks",          64'({inst_ack[0], data_ack[0]}), 64'd0);
        check("rst_inst_rdata",    inst_read_data[0], 64'd0);
        reset_n = 1'b1;
        tick();

        // Round-robin ties: data first after reset, and again on the next tie
        tie(0, 64'hA5A5_0000_1111_2222, first, ok);
        check("rr_tie1_done",  64'(ok), 64'd1);
        check("rr_tie1_first", 64'(first), 64'd1);
        check("rr_tie1_inst_rdata", inst_read_data[0], 64'hA5A5_0000_1111_2222);
        check("rr_tie1_data_rdata", data_read_data[0], 64'd0);
        tick();
        tie(0, 64'h5A5A_3333_4444_5555, first, ok);
        check("rr_tie2_first", 64'(first), 64'd1);
        check("rr_tie2_inst_rdata", inst_read_data[0], 64'h5A5A_3333_4444_5555);
        tick();

        // Fixed priority: data wins every tie
        for (int r = 0; r < 3; r++) begin
            tie(1, 64'(r), first, ok);
            check($sformatf("fp_tie%0d_done", r),  64'(ok), 64'd1);
            check($sformatf("fp_tie%0d_first", r), 64'(first), 64'd1);
            tick();
        end

        // Instruction-only read
        mem_read_data[0]  = 64'hDEAD_BEEF_CAFE_F00D;
        inst_address[0]   = 26'h0001234;
        inst_rd_enable[0] = 1'b1;
        wait_ack(0, 1'b0, lat);
        check("inst_rd_latency", 64'(lat), 64'd8);
        check("inst_rd_data",    inst_read_data[0], 64'hDEAD_BEEF_CAFE_F00D);
        check("inst_rd_size",    64'(mem_rd_wr_size[0]), 64'd2);
        check("inst_rd_addr",    64'(mem_address[0]), 64'h1234);
        check("inst_rd_grant",   64'(arb_grant_data[0]), 64'd0);
        check("inst_rd_data_port_unchanged", data_read_data[0], 64'd0);
        tick();
        check("inst_ack_pulse",  64'(inst_ack[0]), 64'd0);

        // Data byte read
        mem_read_data[0]   = 64'h0123_4567_89AB_CDEF;
        data_address[0]    = 26'h0000041;
        data_rd_wr_size[0] = 2'b00;
        data_rd_enable[0]  = 1'b1;
        wait_ack(0, 1'b1, lat);
        check("data_rd_latency", 64'(lat), 64'd8);
        check("data_rd_data",    data_read_data[0], 64'h0123_4567_89AB_CDEF);
        check("data_rd_inst_unchanged", inst_read_data[0], 64'hDEAD_BEEF_CAFE_F00D);
        check("data_rd_size",    64'(mem_rd_wr_size[0]), 64'd0);
        check("data_rd_grant",   64'(arb_grant_data[0]), 64'd1);
        tick();

        // Data half write, with master fields changing during WAIT
        mem_read_data[0]   = 64'hFFFF_FFFF_FFFF_FFFF;
        data_address[0]    = 26'h0000040;
        data_rd_wr_size[0] = 2'b01;
        data_write_data[0] = 64'h1122_3344_5566_7788;
        data_wr_enable[0]  = 1'b1;
        tick();
        check("wr_issue_wr_en", 64'({mem_wr_enable[0], mem_rd_enable[0]}), 64'd2);
        repeat (3) tick();
        check("wr_wait_wdata", mem_write_data[0], 64'h1122_3344_5566_7788);
        check("wr_wait_size",  64'(mem_rd_wr_size[0]), 64'd1);
        check("wr_wait_en_dropped", 64'({mem_wr_enable[0], mem_rd_enable[0]}), 64'd0);
        data_address[0]    = 26'h3FFFFFC;
        data_write_data[0] = 64'd0;
        data_rd_wr_size[0] = 2'b11;
        tick();
        check("wr_wait_addr_stable",  64'(mem_address[0]), 64'h40);
        check("wr_wait_wdata_stable", mem_write_data[0], 64'h1122_3344_5566_7788);
        wait_ack(0, 1'b1, lat);
        check("wr_remaining_latency", 64'(lat), 64'd3);
        check("wr_data_rdata_unchanged", data_read_data[0], 64'h0123_4567_89AB_CDEF);
        check("wr_inst_rdata_unchanged", inst_read_data[0], 64'hDEAD_BEEF_CAFE_F00D);
        tick();
        check("wr_ack_pulse", 64'(data_ack[0]), 64'd0);

        // Reset during WAIT of a data read
        mem_read_data[0]   = 64'h5555_5555_5555_5555;
        data_address[0]    = 26'h0000155;
        data_rd_wr_size[0] = 2'b11;
        data_rd_enable[0]  = 1'b1;
        repeat (4) tick();
        check("prerst_grant", 64'(arb_grant_data[0]), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_mem_address", 64'(mem_address[0]), 64'd0);
        check("arst_mem_size",    64'(mem_rd_wr_size[0]), 64'd0);
        check("arst_grant",       64'(arb_grant_data[0]), 64'd0);
        check("arst_data_rdata",  data_read_data[0], 64'd0);
        check("arst_inst_rdata",  inst_read_data[0], 64'd0);
        data_rd_enable[0] = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (data_ack[0] || inst_ack[0]) seen = 1;
        end
        check("arst_no_ack", 64'(seen), 64'd0);
        reset_n = 1'b1;
        tick();
        mem_read_data[0]  = 64'h0F0F_0F0F_F0F0_F0F0;
        inst_address[0]   = 26'h0002468;
        inst_rd_enable[0] = 1'b1;
        wait_ack(0, 1'b0, lat);
        check("post_rst_latency", 64'(lat), 64'd8);
        check("post_rst_rdata",   inst_read_data[0], 64'h0F0F_0F0F_F0F0_F0F0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_sdram_arbiter
`default_nettype wire
